// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared channel count, channel-index type and FSM state encoding
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module : rr_pick4
// Brief  : Combinational search for the first set mask bit starting at ptr
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick4
    import demux_pkg::*;
(
    input  logic [3:0] mask,
    input  ch_idx_t    ptr,
    output ch_idx_t    index,
    output logic       found
);

    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    ch_idx_t    w_off;

    // Doubling the mask turns the modulo-4 rotation into a plain slice.
    assign w_dbl = {mask, mask};
    assign w_rot = w_dbl[ptr +: 4];

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign index = ptr + w_off;
    assign found = |mask;

endmodule

`default_nettype wire

// File: rtl/demux_rr_dispatcher.sv
// ============================================================================
// Module : demux_rr_dispatcher
// Brief  : One-word buffered demux to four channels, fixed or round-robin
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              mode_i,
    input  logic [1:0]        sel_i,
    input  logic [3:0]        en_i,
    output logic [3:0]        out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic [3:0]        out_ready_i,
    output logic [15:0]       count_o
);

    state_t            r_state;
    ch_idx_t           r_target;
    ch_idx_t           r_ptr;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_out_valid;
    logic [15:0]       r_count;

    ch_idx_t w_rr_idx;
    logic    w_rr_found;
    ch_idx_t w_target;
    logic    w_eligible;
    logic    w_deliver;
    logic    w_accept;

    rr_pick4 u_rr_pick4 (
        .mask  (en_i),
        .ptr   (r_ptr),
        .index (w_rr_idx),
        .found (w_rr_found)
    );

    assign w_eligible = mode_i ? w_rr_found : en_i[sel_i];
    assign w_target   = mode_i ? w_rr_idx : sel_i;
    // Only the held target's ready matters; other channels are ignored.
    assign w_deliver  = (r_state == ST_BUSY) && out_ready_i[r_target];
    assign in_ready_o = w_eligible && ((r_state == ST_IDLE) || w_deliver);
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_target    <= 2'd0;
            r_ptr       <= 2'd0;
            r_data      <= '0;
            r_out_valid <= 4'b0000;
            r_count     <= 16'd0;
        end else begin
            if (w_deliver) begin
                r_count <= r_count + 16'd1;
            end
            if (w_accept) begin
                r_state     <= ST_BUSY;
                r_target    <= w_target;
                r_data      <= in_data_i;
                r_out_valid <= 4'b0001 << w_target;
                if (mode_i) begin
                    r_ptr <= w_target + 2'd1;
                end
            end else if (w_deliver) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 4'b0000;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_data;
    assign count_o     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
// ============================================================================
// Module : tb_demux_rr_dispatcher
// Brief  : Directed self-checking bench for demux_rr_dispatcher
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demux_rr_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  en;
    logic [3:0]  out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_ready;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;

    demux_rr_dispatcher #(.DATA_W(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .sel_i       (sel),
        .en_i        (en),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_full [8];
        logic [1:0] rr_sparse [4];
        rr_full   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        rr_sparse = '{2'd1, 2'd3, 2'd1, 2'd3};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; mode = 1'b0;
        sel = 2'd0; en = 4'hF; out_ready = 4'hF;
        #3;
        chk("reset_valid", {28'd0, out_valid}, 32'h0);
        chk("reset_count", {16'd0, count}, 32'h0);
        chk("reset_data", {24'd0, out_data}, 32'h0);
        #9;
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, in_ready}, 32'h1);

        // Fixed mode to channel 2
        sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fixed_valid", {28'd0, out_valid}, 32'h4);
        chk("fixed_data", {24'd0, out_data}, 32'hA5);
        tick();
        chk("fixed_count", {16'd0, count}, 32'd1);
        chk("fixed_idle", {28'd0, out_valid}, 32'h0);

        // Round-robin, all enabled, back-to-back
        mode = 1'b1; en = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            chk("rr_full_valid", {28'd0, out_valid}, 32'h1 << rr_full[i]);
            chk("rr_full_data", {24'd0, out_data}, 32'h10 + i);
            chk("rr_full_count", {16'd0, count}, 32'd1 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("rr_full_total", {16'd0, count}, 32'd9);

        // Round-robin, sparse mask, pointer wraps 3 -> 0
        en = 4'b1010; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h20 + 8'(i);
            tick();
            chk("rr_sparse_valid", {28'd0, out_valid}, 32'h1 << rr_sparse[i]);
        end
        in_valid = 1'b0;
        tick();
        chk("rr_sparse_total", {16'd0, count}, 32'd13);

        // Held word on channel 1 while its ready is low
        mode = 1'b0; sel = 2'd1; en = 4'hF; in_data = 8'h5C;
        out_ready = 4'b1101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sel = 2'd3; en = 4'b1000; mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {28'd0, out_valid}, 32'h2);
            chk("hold_data", {24'd0, out_data}, 32'h5C);
            chk("hold_ready", {31'd0, in_ready}, 32'h0);
            tick();
        end
        chk("hold_count", {16'd0, count}, 32'd13);
        out_ready = 4'hF;
        #1;
        chk("release_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("release_count", {16'd0, count}, 32'd14);
        chk("release_idle", {28'd0, out_valid}, 32'h0);

        // Ineligible inputs stall
        mode = 1'b1; en = 4'b0000; in_valid = 1'b1; in_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rr_none_ready", {31'd0, in_ready}, 32'h0);
            tick();
            chk("rr_none_valid", {28'd0, out_valid}, 32'h0);
        end
        mode = 1'b0; sel = 2'd0; en = 4'b1110;
        #1;
        chk("fixed_dis_ready", {31'd0, in_ready}, 32'h0);
        tick();
        chk("fixed_dis_valid", {28'd0, out_valid}, 32'h0);
        in_valid = 1'b0;

        // Async reset while BUSY with count=5 and ptr nonzero
        rst_n = 1'b0;
        #1;
        chk("rst2_count", {16'd0, count}, 32'h0);
        rst_n = 1'b1;
        mode = 1'b1; en = 4'hF; out_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 4'h0;
        tick();
        chk("busy_valid", {28'd0, out_valid}, 32'h2);
        chk("busy_count", {16'd0, count}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {28'd0, out_valid}, 32'h0);
        chk("async_count", {16'd0, count}, 32'h0);
        chk("async_data", {24'd0, out_data}, 32'h0);
        rst_n = 1'b1;
        out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        chk("ptr_zero_valid", {28'd0, out_valid}, 32'h1);
        chk("ptr_zero_data", {24'd0, out_data}, 32'h99);
        tick();
        chk("final_count", {16'd0, count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
